// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate
// formats, the decode-stage output bundle and small decode helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Everything the decode stage hands to execute, registered as one unit.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_out_t;

    localparam dec_out_t DEC_OUT_ZERO = '{
        pc:       32'h0,
        rs1_val:  32'h0,
        rs2_val:  32'h0,
        imm:      32'h0,
        rd:       5'd0,
        alu_op:   4'b0000,
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        branch:   1'b0,
        jump:     1'b0,
        illegal:  1'b0
    };

    // Immediate layout selected by the major opcode; OP and unknown opcodes carry none.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // Register operand with x0 hardwired to zero and writeback forwarding.
    function automatic logic [31:0] bypass_val(
        input logic [4:0]  num,
        input logic [31:0] rf_data,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        logic [31:0] val;
        if (num == 5'd0) begin
            val = 32'h0;
        end else if (wb_we && (wb_rd == num)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the immediate
// field of an RV32I instruction according to its opcode.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt_s;

    assign fmt_s = imm_fmt_of(instr[6:0]);

    // Assemble the immediate for the decoded format, sign-extended from bit 31
    always_comb begin
        imm = 32'h0;
        case (fmt_s)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-operand fetch with writeback bypass, control
// decode, load-use interlock, and a single registered output slot with
// valid/ready handshakes on both sides.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_num,
    output logic [4:0]      rs2_num,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_alu_op,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [31:0] imm_s;
    logic        wr_en_s;
    logic        uses_rs2_s;
    logic        stall_s;
    logic        in_xfer_s;
    dec_out_t    dec_s;
    dec_out_t    dout_r;
    logic        out_valid_r;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign rs1_num  = in_instr[19:15];
    assign rs2_num  = in_instr[24:20];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm_s)
    );

    // rs2 only matters for the load-use check when the instruction reads it as a register
    assign uses_rs2_s = (opcode_s == OPC_OP) || (opcode_s == OPC_STORE) || (opcode_s == OPC_BRANCH);

    // A load in the output slot whose result is needed now forces one bubble
    assign stall_s = out_valid_r && dout_r.memread && (dout_r.rd != 5'd0) &&
                     ((dout_r.rd == rs1_num) || ((dout_r.rd == rs2_num) && uses_rs2_s));

    assign in_ready  = (!out_valid_r || out_ready) && !stall_s && !flush;
    assign in_xfer_s = in_valid && in_ready;

    // Decode the incoming instruction into the next output bundle
    always_comb begin
        dec_s         = DEC_OUT_ZERO;
        wr_en_s       = 1'b0;
        dec_s.pc      = in_pc;
        dec_s.rs1_val = bypass_val(rs1_num, rs1_data, wb_regwrite, wb_rd, wb_data);
        dec_s.rs2_val = bypass_val(rs2_num, rs2_data, wb_regwrite, wb_rd, wb_data);
        dec_s.imm     = imm_s;
        dec_s.rd      = in_instr[11:7];
        dec_s.alu_op  = ALU_ADD;
        case (opcode_s)
            OPC_OP: begin
                dec_s.alu_op = {in_instr[30], funct3_s};
                wr_en_s      = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the shift-right pair uses funct7[5] to pick arithmetic vs logical
                dec_s.alu_op = {((funct3_s == 3'b101) ? in_instr[30] : 1'b0), funct3_s};
                wr_en_s      = 1'b1;
            end
            OPC_LOAD: begin
                dec_s.memread = 1'b1;
                wr_en_s       = 1'b1;
            end
            OPC_STORE: begin
                dec_s.memwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.alu_op = ALU_SUB;
                dec_s.branch = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                wr_en_s = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_s.jump = 1'b1;
                wr_en_s    = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        // Writes to x0 are dropped here so later stages never see them
        dec_s.regwrite = wr_en_s && (in_instr[11:7] != 5'd0);
    end

    // Output slot: flush wins, then capture, then drain, otherwise hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            dout_r      <= DEC_OUT_ZERO;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            dout_r      <= dec_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_pc       = dout_r.pc;
    assign out_rs1_val  = dout_r.rs1_val;
    assign out_rs2_val  = dout_r.rs2_val;
    assign out_imm      = dout_r.imm;
    assign out_rd       = dout_r.rd;
    assign out_alu_op   = dout_r.alu_op;
    assign out_regwrite = dout_r.regwrite;
    assign out_memread  = dout_r.memread;
    assign out_memwrite = dout_r.memwrite;
    assign out_branch   = dout_r.branch;
    assign out_jump     = dout_r.jump;
    assign out_illegal  = dout_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-assembled RV32I instructions with
// hand-computed expected decode results, checked one scenario per task.
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_num;
    logic [4:0]  rs2_num;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [3:0]  out_alu_op;
    logic        out_regwrite;
    logic        out_memread;
    logic        out_memwrite;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;

    int vectors;
    int miscompares;

    decode_stage #(.XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_num      (rs1_num),
        .rs2_num      (rs2_num),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_alu_op   (out_alu_op),
        .out_regwrite (out_regwrite),
        .out_memread  (out_memread),
        .out_memwrite (out_memwrite),
        .out_branch   (out_branch),
        .out_jump     (out_jump),
        .out_illegal  (out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'h00708293; in_pc = 32'h0000_0040;
        out_ready = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out_regwrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite got %b want 0", out_regwrite); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", out_pc); end
        vectors++; if (out_imm !== 32'h0) begin miscompares++; $display("FAIL reset_imm got %h want 0", out_imm); end
        in_valid = 1'b0;
        #2 reset = 1'b0;
    endtask

    task automatic test_basic();
        // addi x5, x1, 7
        in_valid = 1'b1; in_instr = 32'h00708293; in_pc = 32'h0000_0100; rs1_data = 32'h1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        vectors++; if (rs1_num !== 5'd1) begin miscompares++; $display("FAIL basic_rs1_num got %0d want 1", rs1_num); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", out_valid); end
        vectors++; if (out_rd !== 5'd5) begin miscompares++; $display("FAIL basic_rd got %0d want 5", out_rd); end
        vectors++; if (out_imm !== 32'h7) begin miscompares++; $display("FAIL basic_imm got %h want 7", out_imm); end
        vectors++; if (out_rs1_val !== 32'h1) begin miscompares++; $display("FAIL basic_rs1_val got %h want 1", out_rs1_val); end
        vectors++; if (out_regwrite !== 1'b1) begin miscompares++; $display("FAIL basic_regwrite got %b want 1", out_regwrite); end
        vectors++; if (out_pc !== 32'h100) begin miscompares++; $display("FAIL basic_pc got %h want 100", out_pc); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_decode_table();
        logic [31:0] t_instr [8];
        logic [31:0] t_imm   [8];
        logic [3:0]  t_alu   [8];
        logic [5:0]  t_flags [8]; // {regwrite, memread, memwrite, branch, jump, illegal}
        logic [5:0]  got;
        t_instr[0] = 32'h00512423; t_imm[0] = 32'h0000_0008; t_alu[0] = 4'b0000; t_flags[0] = 6'b001000; // sw x5,8(x2)
        t_instr[1] = 32'hFE208EE3; t_imm[1] = 32'hFFFF_FFFC; t_alu[1] = 4'b1000; t_flags[1] = 6'b000100; // beq x1,x2,-4
        t_instr[2] = 32'h008000EF; t_imm[2] = 32'h0000_0008; t_alu[2] = 4'b0000; t_flags[2] = 6'b100010; // jal x1,8
        t_instr[3] = 32'h40C58533; t_imm[3] = 32'h0000_0000; t_alu[3] = 4'b1000; t_flags[3] = 6'b100000; // sub x10,x11,x12
        t_instr[4] = 32'h40335293; t_imm[4] = 32'h0000_0403; t_alu[4] = 4'b1101; t_flags[4] = 6'b100000; // srai x5,x6,3
        t_instr[5] = 32'h00000013; t_imm[5] = 32'h0000_0000; t_alu[5] = 4'b0000; t_flags[5] = 6'b000000; // nop: rd=x0
        t_instr[6] = 32'h123454B7; t_imm[6] = 32'h1234_5000; t_alu[6] = 4'b0000; t_flags[6] = 6'b100000; // lui x9,0x12345
        t_instr[7] = 32'hFFFFFFFF; t_imm[7] = 32'h0000_0000; t_alu[7] = 4'b0000; t_flags[7] = 6'b000001; // illegal
        out_ready = 1'b1; rs1_data = 32'h0; rs2_data = 32'h0; wb_regwrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = t_instr[i]; in_pc = 32'h200 + 32'(i * 4);
            step();
            got = {out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_illegal};
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL table%0d_valid got %b want 1", i, out_valid); end
            vectors++; if (out_imm !== t_imm[i]) begin miscompares++; $display("FAIL table%0d_imm got %h want %h", i, out_imm, t_imm[i]); end
            vectors++; if (out_alu_op !== t_alu[i]) begin miscompares++; $display("FAIL table%0d_alu_op got %b want %b", i, out_alu_op, t_alu[i]); end
            vectors++; if (got !== t_flags[i]) begin miscompares++; $display("FAIL table%0d_flags got %b want %b", i, got, t_flags[i]); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        // lw x6, 0(x2)
        in_valid = 1'b1; in_instr = 32'h00012303; in_pc = 32'h300;
        step();
        vectors++; if (out_memread !== 1'b1) begin miscompares++; $display("FAIL lu_memread got %b want 1", out_memread); end
        // addi x8,x1,6 reads bits 24:20 == 6 only as an immediate: no stall
        in_instr = 32'h00608413;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_imm_no_stall got %b want 1", in_ready); end
        // add x7, x6, x3 depends on the load
        in_instr = 32'h003303B3; in_pc = 32'h304;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall got %b want 0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_resume got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lu_add_valid got %b want 1", out_valid); end
        vectors++; if (out_rd !== 5'd7) begin miscompares++; $display("FAIL lu_add_rd got %0d want 7", out_rd); end
        vectors++; if (out_memread !== 1'b0) begin miscompares++; $display("FAIL lu_add_memread got %b want 0", out_memread); end
        step();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h003303B3; rs1_data = 32'h66; rs2_data = 32'h3;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        step();
        vectors++; if (out_rs2_val !== 32'hDEADBEEF) begin miscompares++; $display("FAIL byp_rs2 got %h want deadbeef", out_rs2_val); end
        vectors++; if (out_rs1_val !== 32'h66) begin miscompares++; $display("FAIL byp_rs1 got %h want 66", out_rs1_val); end
        // add x7, x0, x3: x0 reads zero even with a write to x0 pending
        in_instr = 32'h003003B3; rs1_data = 32'h55; wb_rd = 5'd0; wb_data = 32'h12345678;
        step();
        in_valid = 1'b0; wb_regwrite = 1'b0;
        vectors++; if (out_rs1_val !== 32'h0) begin miscompares++; $display("FAIL byp_x0 got %h want 0", out_rs1_val); end
        vectors++; if (out_rs2_val !== 32'h3) begin miscompares++; $display("FAIL byp_nohit got %h want 3", out_rs2_val); end
        step();
    endtask

    task automatic test_back_to_back_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00708293; in_pc = 32'h400; rs1_data = 32'h1;
        step();
        in_instr = 32'h123454B7; in_pc = 32'h404;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_in_ready got %b want 0", c, in_ready); end
            vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_imm !== 32'h7 || out_pc !== 32'h400) begin
                miscompares++; $display("FAIL bp%0d_hold got v=%b rd=%0d imm=%h pc=%h want v=1 rd=5 imm=7 pc=400", c, out_valid, out_rd, out_imm, out_pc);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_rd !== 5'd9 || out_imm !== 32'h12345000 || out_pc !== 32'h404) begin
            miscompares++; $display("FAIL bp_next got rd=%0d imm=%h pc=%h want rd=9 imm=12345000 pc=404", out_rd, out_imm, out_pc);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00708293; in_pc = 32'h500;
        step();
        flush = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        step();
        in_valid = 1'b0;
        vectors++; if (out_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag got %b want 1", out_illegal); end
        vectors++; if (out_regwrite !== 1'b0) begin miscompares++; $display("FAIL illegal_regwrite got %b want 0", out_regwrite); end
        step();
    endtask

    task automatic test_reset_mid_transfer();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00708293; in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %b want 0", out_valid); end
        vectors++; if (out_rd !== 5'd0 || out_regwrite !== 1'b0) begin miscompares++; $display("FAIL areset_data got rd=%0d rw=%b want 0 0", out_rd, out_regwrite); end
        #2 reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h123454B7; in_pc = 32'h604;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd9) begin miscompares++; $display("FAIL areset_capture got v=%b rd=%0d want 1 9", out_valid, out_rd); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_decode_table();
        test_load_use();
        test_bypass();
        test_back_to_back_backpressure();
        test_flush();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  in  1 / in_ready  out  1: fetch handshake.
REQ-005 Port: in_instr  in  32 / in_pc  in  32: instruction and its PC.
REQ-006 Port: rs1_num  out  5 / rs2_num  out  5: register-file read addresses, combinational from in_instr[19:15] and in_instr[24:20].
REQ-007 Port: rs1_data  in  32 / rs2_data  in  32: register-file combinational read data.
REQ-008 Port: wb_regwrite  in  1 / wb_rd  in  5 / wb_data  in  32: writeback write port, also used for the bypass.
REQ-009 Port: flush  in  1: discard the held and the incoming instruction.
REQ-010 Port: out_valid  out  1 / out_ready  in  1: execute-stage handshake.
REQ-011 Port: out_pc  32, out_rs1_val  32, out_rs2_val  32, out_imm  32, out_rd  5, out_alu_op  4: outputs, registered.
REQ-012 Port: out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_illegal: outputs, 1 bit each, registered.

Function
REQ-013 Transfer: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-014 in_ready: equals (!out_valid | out_ready) & !stall & !flush.
REQ-015 Capture: on an input transfer, all out_* are loaded on the next edge and out_valid is set to 1.
REQ-016 Drain: an output transfer with no input transfer clears out_valid.
REQ-017 Hold: while out_valid & !out_ready, every out_* is held stable.
REQ-018 stall: asserted when out_valid & out_memread & out_rd!=0 & (out_rd==rs1_num | (out_rd==rs2_num & the incoming opcode is OP, STORE or BRANCH)); one bubble results.
REQ-019 Bypass: rs1 value is 0 if rs1_num==0; else wb_data if wb_regwrite & wb_rd==rs1_num; else rs1_data. rs2 is handled identically.
REQ-020 Opcodes decoded: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-021 Immediates: I, S, B, U and J formats, sign-extended from bit 31; OP yields imm 0.
REQ-022 out_alu_op encoding:
- OP: {funct7[5], funct3}.
- OP-IMM: {funct3==101 ? funct7[5] : 0, funct3}.
- BRANCH: 4'b1000 (SUB).
- All other opcodes: 4'b0000 (ADD).
REQ-023 Control flags:
- out_regwrite=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
- out_regwrite is forced 0 when rd==0.
- out_memread=1 for LOAD; out_memwrite=1 for STORE; out_branch=1 for BRANCH; out_jump=1 for JAL and JALR.
REQ-024 Illegal opcode: any other opcode sets out_illegal=1 with all other control flags 0; the instruction still transfers.
REQ-025 Flush: flush forces out_valid to 0 on the next edge; flush dominates a simultaneous capture or hold.

Reset
REQ-026 While reset is high, out_valid and every control flag are 0 and all data outputs are 0; this takes effect asynchronously.
REQ-027 Reset asserted mid-transfer discards the held instruction; the first capture can occur on the first edge after deassertion.

Structure
REQ-028 A shared package riscv_pkg holds the opcode constants, the alu_op encodings and the immediate-format enum.
REQ-029 A combinational sub-module imm_gen produces out_imm from the instruction.

Verification
REQ-030 Basic decode: after reset, addi x5,x1,7 (0x00708293) with rs1_data=0x1 -> next cycle out_valid=1, out_rd=5, out_imm=7, out_rs1_val=0x1, out_regwrite=1.
REQ-031 Load-use stall: lw x6,0(x2) (0x00012303) followed by add x7,x6,x3 (0x003303B3), out_ready=1 -> in_ready=0 for one cycle, one bubble, then add is captured.
REQ-032 Bypass: add x7,x6,x3 with wb_regwrite=1, wb_rd=3, wb_data=0xDEADBEEF, rs2_data=0x3 -> out_rs2_val=0xDEADBEEF.
REQ-033 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0; with out_ready=1 the next instruction is captured on the following edge.
REQ-034 Flush and illegal opcode: flush=1 while holding -> out_valid=0 on the next cycle; in_instr=0xFFFFFFFF -> out_illegal=1, out_regwrite=0.
